// File: rtl/frac_divider_seq.sv
// Sequential unsigned fixed-point divider: Q = N*2^FRAC / D.
// Restoring radix-2, one quotient bit per cycle, optional round half-up.
module frac_divider_seq #(
  parameter int NW   = 16,
  parameter int DW   = 16,
  parameter int QW   = 16,
  parameter int FRAC = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [NW-1:0] Numerator,
  input  logic [DW-1:0] Divisor,
  input  logic          Round,
  output logic [QW-1:0] Quotient,
  output logic          Ack,
  output logic          Busy,
  output logic          Ovf,
  output logic          DivZero
);

  localparam int ITER = NW + FRAC + 1;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FINISH
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [NW-1:0]   n_q;
  logic [DW-1:0]   d_q;
  logic            round_q;
  logic [DW:0]     r_q;
  logic [ITER-1:0] e_q;
  logic [CW-1:0]   cnt_q;

  logic [DW:0]     r_sh;
  logic            r_ge;
  logic [DW:0]     r_nx;
  logic [ITER-1:0] v;
  logic            d_zero;
  logic            sat;

  // One restoring step; the numerator register shifts out X MSB first,
  // and the FRAC+1 appended zero bits arrive as it empties.
  always_comb begin
    r_sh   = {r_q[DW-1:0], n_q[NW-1]};
    r_ge   = (r_sh >= {1'b0, d_q});
    r_nx   = r_ge ? (r_sh - {1'b0, d_q}) : r_sh;
    v      = {1'b0, e_q[ITER-1:1]}
           + {{(ITER-1){1'b0}}, round_q & e_q[0]};
    d_zero = (d_q == '0);
    sat    = d_zero || ((v >> QW) != '0);
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; Start only matters in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Start) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Busy = (state_q != IDLE);

  // Operand capture, iteration datapath and result write-back.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      n_q      <= '0;
      d_q      <= '0;
      round_q  <= 1'b0;
      r_q      <= '0;
      e_q      <= '0;
      cnt_q    <= '0;
      Quotient <= '0;
      Ack      <= 1'b0;
      Ovf      <= 1'b0;
      DivZero  <= 1'b0;
    end else begin
      Ack <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (Start) begin
            n_q      <= Numerator;
            d_q      <= Divisor;
            round_q  <= Round;
            r_q      <= '0;
            e_q      <= '0;
            cnt_q    <= CW'(ITER - 1);
            Quotient <= '0;
            Ovf      <= 1'b0;
            DivZero  <= 1'b0;
          end
        end
        CALC: begin
          n_q   <= n_q << 1;
          r_q   <= r_nx;
          e_q   <= {e_q[ITER-2:0], r_ge};
          cnt_q <= cnt_q - 1'b1;
        end
        FINISH: begin
          Quotient <= sat ? '1 : v[QW-1:0];
          Ovf      <= sat;
          DivZero  <= d_zero;
          Ack      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_divider_seq.sv
// Directed and randomised bench for frac_divider_seq.
// Expected values are hand-computed or from a behavioural model.
module tb_frac_divider_seq;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] Numerator;
  logic [15:0] Divisor;
  logic        Round;
  logic [15:0] Quotient;
  logic        Ack;
  logic        Busy;
  logic        Ovf;
  logic        DivZero;

  int n_cmp  = 0;
  int n_fail = 0;

  frac_divider_seq dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Numerator (Numerator),
    .Divisor   (Divisor),
    .Round     (Round),
    .Quotient  (Quotient),
    .Ack       (Ack),
    .Busy      (Busy),
    .Ovf       (Ovf),
    .DivZero   (DivZero)
  );

  always #5 Clk = ~Clk;

  // Behavioural reference: {ovf, quotient}
  function automatic logic [16:0] ref_q(
    input logic [15:0] n, input logic [15:0] d, input logic r);
    longint x, e, t, vv;
    x  = longint'(n) << 9;
    e  = x / longint'(d);
    t  = e >> 1;
    vv = t + ((r && (e % 2 == 1)) ? 1 : 0);
    if (vv >= 65536) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(vv)};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] n, input logic [15:0] d,
                        input logic r, output logic [15:0] q,
                        output logic o, output logic z,
                        output int lat, output int bcnt);
    Numerator = n;
    Divisor   = d;
    Round     = r;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    bcnt  = Busy ? 1 : 0;
    lat   = -1;
    for (int j = 1; j <= 60; j++) begin
      tick();
      if (Busy) bcnt++;
      if (Ack) begin
        lat = j;
        break;
      end
    end
    q = Quotient;
    o = Ovf;
    z = DivZero;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b0;
    Numerator = '0;
    Divisor = '0;
    Round = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (Quotient !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_q: got %h want 0000", Quotient);
    end
    n_cmp++;
    if ({Ack, Busy, Ovf, DivZero} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0000",
               {Ack, Busy, Ovf, DivZero});
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_recip();
    logic [15:0] q;
    logic o, z;
    int lat, bc;
    run_op(16'h8000, 16'h0400, 1'b0, q, o, z, lat, bc);
    n_cmp++;
    if (q !== 16'h2000) begin
      n_fail++;
      $display("FAIL recip_q: got %h want 2000", q);
    end
    n_cmp++;
    if ({o, z} !== 2'b00) begin
      n_fail++;
      $display("FAIL recip_flags: got %b want 00", {o, z});
    end
    n_cmp++;
    if (lat !== 26) begin
      n_fail++;
      $display("FAIL recip_latency: got %0d want 26", lat);
    end
    n_cmp++;
    if (bc !== 26) begin
      n_fail++;
      $display("FAIL recip_busy: got %0d want 26", bc);
    end
    tick();
    n_cmp++;
    if (Ack !== 1'b0 || Quotient !== 16'h2000) begin
      n_fail++;
      $display("FAIL recip_pulse: ack %b q %h want 0 2000",
               Ack, Quotient);
    end
  endtask

  task automatic test_round();
    logic [15:0] q;
    logic o, z;
    int lat, bc;
    run_op(16'h0002, 16'h0003, 1'b0, q, o, z, lat, bc);
    n_cmp++;
    if (q !== 16'h00AA) begin
      n_fail++;
      $display("FAIL trunc_2_3: got %h want 00aa", q);
    end
    run_op(16'h0002, 16'h0003, 1'b1, q, o, z, lat, bc);
    n_cmp++;
    if (q !== 16'h00AB) begin
      n_fail++;
      $display("FAIL round_2_3: got %h want 00ab", q);
    end
    run_op(16'h0001, 16'h0003, 1'b1, q, o, z, lat, bc);
    n_cmp++;
    if (q !== 16'h0055) begin
      n_fail++;
      $display("FAIL round_1_3: got %h want 0055", q);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] q;
    logic o, z;
    int lat, bc;
    run_op(16'h1234, 16'h0000, 1'b0, q, o, z, lat, bc);
    n_cmp++;
    if ({q, o, z} !== {16'hFFFF, 2'b11}) begin
      n_fail++;
      $display("FAIL div_zero: got q %h ovf %b dz %b want ffff 1 1",
               q, o, z);
    end
    n_cmp++;
    if (lat !== 26) begin
      n_fail++;
      $display("FAIL div_zero_latency: got %0d want 26", lat);
    end
    run_op(16'hFFFF, 16'h0001, 1'b0, q, o, z, lat, bc);
    n_cmp++;
    if ({q, o, z} !== {16'hFFFF, 2'b10}) begin
      n_fail++;
      $display("FAIL overflow: got q %h ovf %b dz %b want ffff 1 0",
               q, o, z);
    end
    run_op(16'h0002, 16'h0003, 1'b0, q, o, z, lat, bc);
    n_cmp++;
    if ({q, o, z} !== {16'h00AA, 2'b00}) begin
      n_fail++;
      $display("FAIL flags_clear: got q %h ovf %b dz %b want 00aa 0 0",
               q, o, z);
    end
  endtask

  task automatic test_busy_ignore();
    int acks = 0;
    logic [15:0] q = '0;
    Numerator = 16'h8000;
    Divisor   = 16'h0400;
    Round     = 1'b0;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (j == 3 || j == 10) begin
        Start     = 1'b1;
        Divisor   = 16'h0001;
        Numerator = 16'h1111;
      end else begin
        Start = 1'b0;
      end
      tick();
      if (Ack) begin
        acks++;
        q = Quotient;
      end
    end
    Start = 1'b0;
    n_cmp++;
    if (acks !== 1) begin
      n_fail++;
      $display("FAIL ignore_acks: got %0d want 1", acks);
    end
    n_cmp++;
    if (q !== 16'h2000) begin
      n_fail++;
      $display("FAIL ignore_q: got %h want 2000", q);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] q;
    logic o, z;
    int lat, bc;
    int acks = 0;
    Numerator = 16'h8000;
    Divisor   = 16'h0400;
    Round     = 1'b0;
    Start     = 1'b1;
    tick();
    Start = 1'b0;
    for (int j = 0; j < 10; j++) tick();
    Reset = 1'b1;
    #1;
    n_cmp++;
    if ({Busy, Ack, Quotient} !== 18'h0) begin
      n_fail++;
      $display("FAIL abort_now: busy %b ack %b q %h want 0 0 0000",
               Busy, Ack, Quotient);
    end
    tick();
    Reset = 1'b0;
    for (int j = 0; j < 30; j++) begin
      tick();
      if (Ack) acks++;
    end
    n_cmp++;
    if (acks !== 0) begin
      n_fail++;
      $display("FAIL abort_no_ack: got %0d want 0", acks);
    end
    run_op(16'h0001, 16'h0004, 1'b0, q, o, z, lat, bc);
    n_cmp++;
    if (q !== 16'h0040 || lat !== 26) begin
      n_fail++;
      $display("FAIL after_abort: got q %h lat %0d want 0040 26",
               q, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] nx, dx;
    logic        rx;
    logic [16:0] expv;
    int          c;
    nx = 16'($urandom);
    dx = 16'($urandom_range(1, 65535));
    rx = 1'($urandom);
    Numerator = nx;
    Divisor   = dx;
    Round     = rx;
    Start     = 1'b1;
    tick();
    expv = ref_q(nx, dx, rx);
    nx = 16'($urandom);
    dx = 16'($urandom_range(1, 65535));
    rx = 1'($urandom);
    Numerator = nx;
    Divisor   = dx;
    Round     = rx;
    for (int i = 0; i < 1000; i++) begin
      c = 0;
      for (int j = 1; j <= 40; j++) begin
        tick();
        if (Ack) begin
          c = j;
          break;
        end
      end
      n_cmp++;
      if (c !== 26) begin
        n_fail++;
        $display("FAIL b2b_period[%0d]: got %0d want 26", i, c);
      end
      n_cmp++;
      if ({Ovf, Quotient} !== expv || DivZero !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_result[%0d]: got %b/%h dz %b want %b/%h",
                 i, Ovf, Quotient, DivZero, expv[16], expv[15:0]);
      end
      if (i == 999) Start = 1'b0;
      tick();
      expv = ref_q(nx, dx, rx);
      nx = 16'($urandom);
      dx = 16'($urandom_range(1, 65535));
      rx = 1'($urandom);
      Numerator = nx;
      Divisor   = dx;
      Round     = rx;
    end
    Start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_recip();
    test_round();
    test_saturate();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_divider_seq.md
# frac_divider_seq

Parametrised sequential unsigned fixed-point divider: Quotient = N·2^FRAC / D, truncated or rounded half-up to QW bits, saturating on overflow and on divide-by-zero. It is the hardware successor of the software 1/x and N/D routines run as CPU programs 1 and 2. It attaches to the CPU as a multi-cycle execution unit using the same Start/Ack handshake the CPU presents to the test bench. With NW=16 it covers 1/x (N=0x8000 denotes 1.0) and general N/D in one block.

## Interface
- NW, 16: numerator width.
- DW, 16: divisor width.
- QW, 16: quotient width.
- FRAC, 8: fractional bits appended below N; ITER = NW+FRAC+1 iterations.
- Clk  input  1  sole clock, rising edge.
- Reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  request; accepted only in IDLE.
- Numerator  input  NW  N, sampled on accept.
- Divisor  input  DW  D, sampled on accept.
- Round  input  1  0 = truncate, 1 = round half-up; sampled on accept.
- Quotient  output  QW  result; held until next accept.
- Ack  output  1  one-cycle done pulse.
- Busy  output  1  high in CALC and FINISH.
- Ovf  output  1  result saturated; valid with Ack, held.
- DivZero  output  1  D was 0; valid with Ack, held.

## Operation
- States: IDLE, CALC, FINISH.
- IDLE: Start=1 at a rising edge latches N, D and Round, clears remainder R (DW+1 bits) and extended quotient E (ITER bits), loads counter with ITER-1, clears Quotient, Ovf and DivZero, and goes to CALC.
- CALC: restoring radix-2 division of X = N·2^(FRAC+1), MSB first, one bit per cycle:
  - R' = {R[DW-1:0], next X bit}.
  - If R' ≥ D: R = R'−D and shift 1 into E; otherwise R = R' and shift 0 into E.
  - Leave for FINISH after the cycle in which the counter is 0.
- FINISH, lasting one cycle, then back to IDLE:
  - T = E[ITER-1:1]; guard bit G = E[0].
  - V = T + (Round & G), computed with enough width to detect carry.
  - If D==0: Quotient = all ones, Ovf=1, DivZero=1.
  - Else if V ≥ 2^QW: Quotient = all ones, Ovf=1.
  - Else: Quotient = V[QW-1:0], Ovf=0, DivZero=0.
  - Ack=1.
- D==0 still runs the full ITER cycles, so latency is data-independent.
- Start while Busy is ignored. The operands are not re-sampled.
- Start held high in IDLE is accepted again on the first IDLE edge after FINISH. Back-to-back operations are allowed with no gap cycle.

## Timing
- Reset values: Quotient=0, Ack=0, Busy=0, Ovf=0, DivZero=0, state IDLE.
- Accept edge = edge k. Busy goes high after edge k. Ack is high for exactly the one cycle following edge k+ITER+1 (defaults: k+26).
- Quotient, Ovf and DivZero change only at accept (cleared) and at the FINISH edge (written). They are stable whenever Ack=1 and afterwards.
- Reset asserted mid-operation aborts the operation at once with no Ack; outputs go to reset values. The first edge after Reset deasserts may accept Start.
- Numerator, Divisor and Round may change freely after the accept edge.

## Test plan
- Defaults, N=0x8000 (1.0), D=0x0400, Round=0 -> Quotient=0x2000, Ovf=0, Ack exactly 26 cycles after the accept edge, Busy high for 26 cycles.
- N=2, D=3: Round=0 -> 0x00AA; Round=1 -> 0x00AB. N=1, D=3, Round=1 -> 0x0055 (guard bit 0, no increment).
- N=0x1234, D=0 -> Quotient=0xFFFF, Ovf=1, DivZero=1, same latency. N=0xFFFF, D=1 -> 0xFFFF, Ovf=1, DivZero=0.
- Start pulsed at cycles 3 and 10 of an operation with Divisor changed at the same time -> ignored; result matches the original operands; exactly one Ack.
- Reset asserted 10 cycles into an operation -> Busy=0 and Quotient=0 immediately, no Ack; a new N=1, D=4 operation afterwards -> 0x0040.
- 1000 random N and D (D≠0) with random Round, Start held high continuously -> every Ack matches the reference model floor/round(N·256/D) with saturation, with one Ack every 27 cycles.
